// File: rtl/id_ex_if.sv
// Decode/execute boundary bundle for id_ex_stage: decode offer, forwarding taps, and ULA-facing outputs.
interface id_ex_if #(
    parameter int N          = 64,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [REG_ADDR_W-1:0] rs1Addr;
    logic [REG_ADDR_W-1:0] rs2Addr;
    logic [N-1:0]          rs1Data;
    logic [N-1:0]          rs2Data;
    logic [N-1:0]          imm;
    logic [N-1:0]          pc;
    logic                  aluSrcA;
    logic                  aluSrcB;
    logic                  isStore;
    logic [3:0]            ALUControlIn;
    logic [REG_ADDR_W-1:0] rdAddr;
    logic                  regWriteIn;
    logic                  exmemRegWrite;
    logic                  exmemIsLoad;
    logic [REG_ADDR_W-1:0] exmemRd;
    logic [N-1:0]          exmemResult;
    logic                  memwbRegWrite;
    logic [REG_ADDR_W-1:0] memwbRd;
    logic [N-1:0]          memwbResult;
    logic                  flush;
    logic                  out_ready;
    logic                  out_valid;
    logic [N-1:0]          dataA;
    logic [N-1:0]          dataB;
    logic [3:0]            ALUControl;
    logic [N-1:0]          storeData;
    logic [REG_ADDR_W-1:0] rdOut;
    logic                  regWriteOut;
    logic [CNT_W-1:0]      stallCount;

    modport master (
        output in_valid, rs1Addr, rs2Addr, rs1Data, rs2Data, imm, pc,
               aluSrcA, aluSrcB, isStore, ALUControlIn, rdAddr, regWriteIn,
               exmemRegWrite, exmemIsLoad, exmemRd, exmemResult,
               memwbRegWrite, memwbRd, memwbResult, flush, out_ready,
        input  in_ready, out_valid, dataA, dataB, ALUControl, storeData,
               rdOut, regWriteOut, stallCount
    );

    modport slave (
        input  in_valid, rs1Addr, rs2Addr, rs1Data, rs2Data, imm, pc,
               aluSrcA, aluSrcB, isStore, ALUControlIn, rdAddr, regWriteIn,
               exmemRegWrite, exmemIsLoad, exmemRd, exmemResult,
               memwbRegWrite, memwbRd, memwbResult, flush, out_ready,
        output in_ready, out_valid, dataA, dataB, ALUControl, storeData,
               rdOut, regWriteOut, stallCount
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: resolves operand forwarding, selects ULA sources, and
// registers them behind a valid/ready handshake with load-use stall detection.
module id_ex_stage #(
    parameter int N          = 64,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input logic     clk,
    input logic     reset,
    id_ex_if.slave  bus
);

    // x0 is hard-wired zero; a load in EX/MEM has no result yet, so it falls through to MEM/WB.
    function automatic logic [N-1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] addr,
        input logic [N-1:0]          rf_data,
        input logic                  ex_wr,
        input logic                  ex_ld,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic [N-1:0]          ex_res,
        input logic                  wb_wr,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic [N-1:0]          wb_res
    );
        if (addr == '0)
            return '0;
        if (ex_wr && !ex_ld && (ex_rd == addr))
            return ex_res;
        if (wb_wr && (wb_rd == addr))
            return wb_res;
        return rf_data;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    logic [N-1:0]          fwd_rs1;
    logic [N-1:0]          fwd_rs2;
    logic                  rs1_used;
    logic                  rs2_used;
    logic                  hazard;
    logic                  ready;
    logic                  capture;

    logic                  vld_p1_d,      vld_p1_q;
    logic [N-1:0]          data_a_p1_d,   data_a_p1_q;
    logic [N-1:0]          data_b_p1_d,   data_b_p1_q;
    logic [3:0]            alu_ctl_p1_d,  alu_ctl_p1_q;
    logic [N-1:0]          store_p1_d,    store_p1_q;
    logic [REG_ADDR_W-1:0] rd_p1_d,       rd_p1_q;
    logic                  reg_wr_p1_d,   reg_wr_p1_q;
    logic [CNT_W-1:0]      stall_cnt_d,   stall_cnt_q;

    always_comb begin
        fwd_rs1 = fwd_sel(bus.rs1Addr, bus.rs1Data, bus.exmemRegWrite, bus.exmemIsLoad,
                          bus.exmemRd, bus.exmemResult, bus.memwbRegWrite, bus.memwbRd,
                          bus.memwbResult);
        fwd_rs2 = fwd_sel(bus.rs2Addr, bus.rs2Data, bus.exmemRegWrite, bus.exmemIsLoad,
                          bus.exmemRd, bus.exmemResult, bus.memwbRegWrite, bus.memwbRd,
                          bus.memwbResult);

        rs1_used = !bus.aluSrcA;
        rs2_used = !bus.aluSrcB || bus.isStore;
        hazard   = bus.in_valid && bus.exmemIsLoad && bus.exmemRegWrite &&
                   (bus.exmemRd != '0) &&
                   ((rs1_used && (bus.exmemRd == bus.rs1Addr)) ||
                    (rs2_used && (bus.exmemRd == bus.rs2Addr)));
        ready    = !hazard && (!vld_p1_q || bus.out_ready);
        capture  = bus.in_valid && ready && !bus.flush;

        vld_p1_d     = vld_p1_q;
        data_a_p1_d  = data_a_p1_q;
        data_b_p1_d  = data_b_p1_q;
        alu_ctl_p1_d = alu_ctl_p1_q;
        store_p1_d   = store_p1_q;
        rd_p1_d      = rd_p1_q;
        reg_wr_p1_d  = reg_wr_p1_q;
        stall_cnt_d  = stall_cnt_q;

        if (bus.flush)
            vld_p1_d = 1'b0;
        else if (capture)
            vld_p1_d = 1'b1;
        else if (bus.out_ready)
            vld_p1_d = 1'b0;

        // Payload only moves on capture, so a stalled output keeps its sampled forwarding values.
        if (capture) begin
            data_a_p1_d  = bus.aluSrcA ? bus.pc  : fwd_rs1;
            data_b_p1_d  = bus.aluSrcB ? bus.imm : fwd_rs2;
            alu_ctl_p1_d = bus.ALUControlIn;
            store_p1_d   = fwd_rs2;
            rd_p1_d      = bus.rdAddr;
            reg_wr_p1_d  = bus.regWriteIn;
        end

        if (hazard && !bus.flush)
            stall_cnt_d = sat_inc(stall_cnt_q);
    end

    // ---- p0 -> p1 register boundary ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1_q     <= 1'b0;
            data_a_p1_q  <= '0;
            data_b_p1_q  <= '0;
            alu_ctl_p1_q <= 4'b0000;
            store_p1_q   <= '0;
            rd_p1_q      <= '0;
            reg_wr_p1_q  <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            vld_p1_q     <= vld_p1_d;
            data_a_p1_q  <= data_a_p1_d;
            data_b_p1_q  <= data_b_p1_d;
            alu_ctl_p1_q <= alu_ctl_p1_d;
            store_p1_q   <= store_p1_d;
            rd_p1_q      <= rd_p1_d;
            reg_wr_p1_q  <= reg_wr_p1_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.in_ready    = ready;
    assign bus.out_valid   = vld_p1_q;
    assign bus.dataA       = data_a_p1_q;
    assign bus.dataB       = data_b_p1_q;
    assign bus.ALUControl  = alu_ctl_p1_q;
    assign bus.storeData   = store_p1_q;
    assign bus.rdOut       = rd_p1_q;
    assign bus.regWriteOut = vld_p1_q && reg_wr_p1_q;
    assign bus.stallCount  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a transaction-level reference model.
module tb_id_ex_stage;
    localparam int N  = 8;
    localparam int RW = 5;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_if #(.N(N), .REG_ADDR_W(RW), .CNT_W(CW)) bus ();
    id_ex_stage #(.N(N), .REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: the instruction currently presented to the ULA
    logic          m_vld = 1'b0;
    logic [N-1:0]  m_a = '0, m_b = '0, m_sd = '0;
    logic [3:0]    m_alu = '0;
    logic [RW-1:0] m_rd = '0;
    logic          m_rw = 1'b0;
    int            m_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [N-1:0] ref_operand(input logic [RW-1:0] a, input logic [N-1:0] rf);
        if (a == 0) return '0;
        if (bus.exmemRegWrite && !bus.exmemIsLoad && bus.exmemRd == a) return bus.exmemResult;
        if (bus.memwbRegWrite && bus.memwbRd == a) return bus.memwbResult;
        return rf;
    endfunction

    function automatic logic ref_hazard();
        logic uses1, uses2;
        uses1 = !bus.aluSrcA && bus.rs1Addr == bus.exmemRd;
        uses2 = (!bus.aluSrcB || bus.isStore) && bus.rs2Addr == bus.exmemRd;
        return bus.in_valid && bus.exmemIsLoad && bus.exmemRegWrite &&
               bus.exmemRd != 0 && (uses1 || uses2);
    endfunction

    task automatic idle();
        bus.in_valid = 0; bus.rs1Addr = 0; bus.rs2Addr = 0; bus.rs1Data = 0; bus.rs2Data = 0;
        bus.imm = 0; bus.pc = 0; bus.aluSrcA = 0; bus.aluSrcB = 0; bus.isStore = 0;
        bus.ALUControlIn = 0; bus.rdAddr = 0; bus.regWriteIn = 0;
        bus.exmemRegWrite = 0; bus.exmemIsLoad = 0; bus.exmemRd = 0; bus.exmemResult = 0;
        bus.memwbRegWrite = 0; bus.memwbRd = 0; bus.memwbResult = 0;
        bus.flush = 0; bus.out_ready = 1;
    endtask

    task automatic randomize_inputs();
        bus.in_valid      = ($urandom_range(0, 3) != 0);
        bus.rs1Addr       = RW'($urandom_range(0, 3));
        bus.rs2Addr       = RW'($urandom_range(0, 3));
        bus.rs1Data       = N'($urandom);
        bus.rs2Data       = N'($urandom);
        bus.imm           = N'($urandom);
        bus.pc            = N'($urandom);
        bus.aluSrcA       = 1'($urandom);
        bus.aluSrcB       = 1'($urandom);
        bus.isStore       = 1'($urandom);
        bus.ALUControlIn  = 4'($urandom);
        bus.rdAddr        = RW'($urandom);
        bus.regWriteIn    = 1'($urandom);
        bus.exmemRegWrite = 1'($urandom);
        bus.exmemIsLoad   = ($urandom_range(0, 3) == 0);
        bus.exmemRd       = RW'($urandom_range(0, 3));
        bus.exmemResult   = N'($urandom);
        bus.memwbRegWrite = 1'($urandom);
        bus.memwbRd       = RW'($urandom_range(0, 3));
        bus.memwbResult   = N'($urandom);
        bus.flush         = ($urandom_range(0, 11) == 0);
        bus.out_ready     = ($urandom_range(0, 9) < 7);
        reset             = ($urandom_range(0, 49) == 0);
    endtask

    // One clock: check in_ready mid-cycle, advance the model, then check registered outputs.
    task automatic step();
        logic hz, rdy;
        logic [N-1:0] op1, op2;
        @(negedge clk);
        hz  = ref_hazard();
        rdy = !hz && (!m_vld || bus.out_ready);
        op1 = ref_operand(bus.rs1Addr, bus.rs1Data);
        op2 = ref_operand(bus.rs2Addr, bus.rs2Data);
        if (!reset) check("in_ready", 64'(bus.in_ready), 64'(rdy));
        @(posedge clk);
        if (reset) begin
            m_vld = 0; m_a = 0; m_b = 0; m_sd = 0; m_alu = 0; m_rd = 0; m_rw = 0; m_cnt = 0;
        end else begin
            if (hz && !bus.flush && m_cnt < 15) m_cnt++;
            if (bus.flush) m_vld = 0;
            else if (bus.in_valid && rdy) begin
                m_vld = 1;
                m_a   = bus.aluSrcA ? bus.pc : op1;
                m_b   = bus.aluSrcB ? bus.imm : op2;
                m_sd  = op2;
                m_alu = bus.ALUControlIn;
                m_rd  = bus.rdAddr;
                m_rw  = bus.regWriteIn;
            end else if (bus.out_ready) m_vld = 0;
        end
        #1;
        check("out_valid", 64'(bus.out_valid), 64'(m_vld));
        check("regWriteOut", 64'(bus.regWriteOut), 64'(m_vld && m_rw));
        check("stallCount", 64'(bus.stallCount), 64'(m_cnt));
        if (m_vld) begin
            check("dataA", 64'(bus.dataA), 64'(m_a));
            check("dataB", 64'(bus.dataB), 64'(m_b));
            check("storeData", 64'(bus.storeData), 64'(m_sd));
            check("ALUControl", 64'(bus.ALUControl), 64'(m_alu));
            check("rdOut", 64'(bus.rdOut), 64'(m_rd));
        end
    endtask

    task automatic do_reset();
        reset = 1; idle(); step(); reset = 0;
    endtask

    initial begin
        reset = 1;
        idle();
        step(); step();
        reset = 0;
        check("rst_out_valid", 64'(bus.out_valid), 0);
        check("rst_dataA", 64'(bus.dataA), 0);
        check("rst_dataB", 64'(bus.dataB), 0);
        check("rst_storeData", 64'(bus.storeData), 0);
        check("rst_ALUControl", 64'(bus.ALUControl), 0);
        check("rst_rdOut", 64'(bus.rdOut), 0);
        check("rst_regWriteOut", 64'(bus.regWriteOut), 0);
        check("rst_stallCount", 64'(bus.stallCount), 0);

        // rs1 plus immediate
        bus.in_valid = 1; bus.rs1Addr = 1; bus.rs1Data = 8'd10; bus.aluSrcB = 1; bus.imm = 8'd20;
        step();
        check("t1_dataA", 64'(bus.dataA), 64'h0A);
        check("t1_dataB", 64'(bus.dataB), 64'h14);
        check("t1_valid", 64'(bus.out_valid), 1);
        idle(); step();

        // EX/MEM beats MEM/WB
        bus.in_valid = 1; bus.rs1Addr = 5; bus.exmemRegWrite = 1; bus.exmemRd = 5;
        bus.exmemResult = 8'h7F; bus.memwbRegWrite = 1; bus.memwbRd = 5; bus.memwbResult = 8'h11;
        step();
        check("t2_ex_priority", 64'(bus.dataA), 64'h7F);
        idle(); step();

        // x0 is never forwarded
        bus.in_valid = 1; bus.rs2Addr = 0; bus.rs2Data = 8'h55; bus.memwbRegWrite = 1;
        bus.memwbRd = 0; bus.memwbResult = 8'hFF;
        step();
        check("t3_x0", 64'(bus.dataB), 64'h00);
        idle(); step();

        // Load-use stall for two cycles, then accept
        do_reset();
        bus.in_valid = 1; bus.rs1Addr = 3; bus.rs1Data = 8'h33; bus.exmemIsLoad = 1;
        bus.exmemRegWrite = 1; bus.exmemRd = 3;
        #1 check("t4_stall1", 64'(bus.in_ready), 0);
        step();
        #1 check("t4_stall2", 64'(bus.in_ready), 0);
        step();
        check("t4_count", 64'(bus.stallCount), 2);
        bus.exmemIsLoad = 0; bus.exmemRegWrite = 0;
        #1 check("t4_release", 64'(bus.in_ready), 1);
        step();
        check("t4_accept", 64'(bus.out_valid), 1);
        check("t4_dataA", 64'(bus.dataA), 64'h33);

        // Backpressure hold for three cycles, then the waiting op goes through
        bus.rs1Data = 8'h44; bus.out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1 check("t5_ready_low", 64'(bus.in_ready), 0);
            step();
            check("t5_hold", 64'(bus.dataA), 64'h33);
        end
        bus.out_ready = 1;
        step();
        check("t5_new", 64'(bus.dataA), 64'h44);

        // Flush beats capture
        bus.flush = 1; bus.regWriteIn = 1;
        step();
        check("t6_valid", 64'(bus.out_valid), 0);
        check("t6_regwrite", 64'(bus.regWriteOut), 0);

        // Store operand alone triggers a hazard
        idle(); bus.in_valid = 1; bus.aluSrcA = 1; bus.aluSrcB = 1; bus.isStore = 1;
        bus.rs2Addr = 2; bus.exmemIsLoad = 1; bus.exmemRegWrite = 1; bus.exmemRd = 2;
        #1 check("t7_store_hz", 64'(bus.in_ready), 0);

        // Counter ignores flushed hazards and saturates
        do_reset();
        bus.in_valid = 1; bus.rs1Addr = 3; bus.exmemIsLoad = 1; bus.exmemRegWrite = 1;
        bus.exmemRd = 3; bus.flush = 1;
        step();
        check("t8_flush_nocount", 64'(bus.stallCount), 0);
        bus.flush = 0;
        for (int i = 0; i < 20; i++) step();
        check("t8_saturate", 64'(bus.stallCount), 15);

        do_reset();
        for (int i = 0; i < 2000; i++) begin
            randomize_inputs();
            step();
        end
        reset = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
